// File: rtl/rgbw_pwm_fader.sv
// rgbw_pwm_fader
//   N-channel PWM generator. Each channel slews its working duty (cur) toward
//   a loaded target duty (tgt) once per PWM period, so duty changes only ever
//   take effect at period boundaries and the outputs never glitch mid-period.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high reset
//   en            tick enable; the period counter advances only when high
//   duty_in       target duties, channel i at duty_in[i*WIDTH +: WIDTH]
//   load          one-cycle strobe capturing duty_in into the target registers
//   fade_step     per-period slew step; 0 jumps straight to target
//   pwm_out       registered PWM outputs
//   duty_cur      duty currently in use per channel
//   load_ack      one-cycle pulse the cycle after a load is captured
//   period_start  one-cycle pulse the cycle after the counter wraps
//   fading        high while any channel's duty differs from its target
module rgbw_pwm_fader #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int STEP_W   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [CHANNELS*WIDTH-1:0] duty_in,
    input  logic                      load,
    input  logic [STEP_W-1:0]         fade_step,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic [CHANNELS*WIDTH-1:0] duty_cur,
    output logic                      load_ack,
    output logic                      period_start,
    output logic                      fading
);

    // Counter runs 0..2^WIDTH-2, giving a period of 2^WIDTH-1 ticks so that a
    // full-scale duty of 2^WIDTH-1 is constantly high.
    localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cur     [CHANNELS];
    logic [WIDTH-1:0] tgt     [CHANNELS];
    logic [WIDTH-1:0] cur_nxt [CHANNELS];
    logic [WIDTH-1:0] tgt_nxt [CHANNELS];
    logic [WIDTH:0]   step_ext;
    logic             boundary;
    logic             fading_nxt;

    assign boundary = en && (cnt == CNT_LAST);
    assign step_ext = (WIDTH+1)'(fade_step);

    // Slew arithmetic is done one bit wider than the duty so that the clamp
    // comparisons cannot wrap; a load on a boundary edge is deliberately not
    // seen by that boundary (it uses the registered tgt).
    always_comb begin
        fading_nxt = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            cur_nxt[i] = cur[i];
            tgt_nxt[i] = load ? duty_in[i*WIDTH +: WIDTH] : tgt[i];
            if (boundary) begin
                if (fade_step == '0) begin
                    cur_nxt[i] = tgt[i];
                end else if (cur[i] < tgt[i]) begin
                    if (({1'b0, cur[i]} + step_ext) >= {1'b0, tgt[i]})
                        cur_nxt[i] = tgt[i];
                    else
                        cur_nxt[i] = cur[i] + step_ext[WIDTH-1:0];
                end else if (cur[i] > tgt[i]) begin
                    if ({1'b0, cur[i]} <= ({1'b0, tgt[i]} + step_ext))
                        cur_nxt[i] = tgt[i];
                    else
                        cur_nxt[i] = cur[i] - step_ext[WIDTH-1:0];
                end
            end
            if (cur_nxt[i] != tgt_nxt[i])
                fading_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            pwm_out      <= '0;
            load_ack     <= 1'b0;
            period_start <= 1'b0;
            fading       <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                cur[i] <= '0;
                tgt[i] <= '0;
            end
        end else begin
            load_ack     <= load;
            period_start <= boundary;
            fading       <= fading_nxt;
            for (int i = 0; i < CHANNELS; i++)
                tgt[i] <= tgt_nxt[i];
            if (en) begin
                cnt <= boundary ? '0 : cnt + WIDTH'(1);
                for (int i = 0; i < CHANNELS; i++) begin
                    cur[i]     <= cur_nxt[i];
                    pwm_out[i] <= (cnt < cur[i]);
                end
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_duty_cur
        assign duty_cur[g*WIDTH +: WIDTH] = cur[g];
    end

endmodule

// File: tb/tb_rgbw_pwm_fader.sv
// Testbench for rgbw_pwm_fader: scenario tasks driving stimulus, with a
// tick-level reference model of the fader kept alongside the DUT.
module tb_rgbw_pwm_fader;
    localparam int CH   = 4;
    localparam int W    = 8;
    localparam int SW   = 4;
    localparam int PER  = 255;

    typedef logic [CH+CH*W+2:0] ovec_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            en;
    logic [CH*W-1:0] duty_in;
    logic            load;
    logic [SW-1:0]   fade_step;
    logic [CH-1:0]   pwm_out;
    logic [CH*W-1:0] duty_cur;
    logic            load_ack;
    logic            period_start;
    logic            fading;

    always #5 clk = ~clk;

    rgbw_pwm_fader #(.CHANNELS(CH), .WIDTH(W), .STEP_W(SW)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .duty_in      (duty_in),
        .load         (load),
        .fade_step    (fade_step),
        .pwm_out      (pwm_out),
        .duty_cur     (duty_cur),
        .load_ack     (load_ack),
        .period_start (period_start),
        .fading       (fading)
    );

    int checks   = 0;
    int failures = 0;

    // reference model state
    int          m_cur [CH];
    int          m_tgt [CH];
    int          m_pos;
    logic [CH-1:0] m_pwm;
    logic        m_ack, m_ps, m_fad;

    // trace mismatch bookkeeping (reported by each scenario)
    int    mism;
    ovec_t bad_act, bad_exp;
    time   bad_t;

    ovec_t dut_vec;
    assign dut_vec = {pwm_out, duty_cur, load_ack, period_start, fading};

    function automatic int fade_to(int c, int t, int s);
        if (s == 0) return t;
        if (c < t)  return (c + s < t) ? c + s : t;
        if (c > t)  return (c - s > t) ? c - s : t;
        return c;
    endfunction

    function automatic ovec_t exp_vec();
        logic [CH*W-1:0] c;
        for (int i = 0; i < CH; i++) c[i*W +: W] = W'(m_cur[i]);
        return {m_pwm, c, m_ack, m_ps, m_fad};
    endfunction

    // Spec-level behaviour for one clock edge given the inputs being applied.
    task automatic model_edge();
        bit bnd;
        if (reset) begin
            for (int i = 0; i < CH; i++) begin m_cur[i] = 0; m_tgt[i] = 0; end
            m_pos = 0; m_pwm = '0; m_ack = 0; m_ps = 0; m_fad = 0;
        end else begin
            bnd = en && (m_pos == PER - 1);
            if (en) begin
                for (int i = 0; i < CH; i++) m_pwm[i] = (m_pos < m_cur[i]);
                m_pos = (m_pos + 1) % PER;
            end
            if (bnd)
                for (int i = 0; i < CH; i++)
                    m_cur[i] = fade_to(m_cur[i], m_tgt[i], int'(fade_step));
            if (load)
                for (int i = 0; i < CH; i++) m_tgt[i] = int'(duty_in[i*W +: W]);
            m_ack = load;
            m_ps  = bnd;
            m_fad = 0;
            for (int i = 0; i < CH; i++) if (m_cur[i] != m_tgt[i]) m_fad = 1;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        if (dut_vec !== exp_vec()) begin
            if (mism == 0) begin bad_act = dut_vec; bad_exp = exp_vec(); bad_t = $time; end
            mism++;
        end
    endtask

    task automatic wait_ps(input int budget, output bit ok);
        ok = 0;
        for (int k = 0; k < budget && !ok; k++) begin
            cyc();
            if (period_start === 1'b1) ok = 1;
        end
    endtask

    task automatic pulse_load(input logic [CH*W-1:0] d);
        duty_in = d; load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; load = 1'b1; duty_in = {$urandom, $urandom} ; fade_step = SW'($urandom);
        cyc(); cyc();
        load = 1'b0;
        checks++;
        if (dut_vec !== '0) begin
            failures++; $display("FAIL reset_state: got %h want 0", dut_vec);
        end
        reset = 1'b0;
        checks++;
        if (mism !== 0) begin
            failures++; $display("FAIL reset_trace: %0d cycles differ, first t=%0t dut=%h model=%h", mism, bad_t, bad_act, bad_exp);
        end
        mism = 0;
    endtask

    task automatic test_steady_half();
        bit ok;
        int hi [CH];
        en = 1'b1; fade_step = '0;
        pulse_load({CH{8'h80}});
        checks++;
        if (load_ack !== 1'b1) begin failures++; $display("FAIL steady_load_ack: got %b want 1", load_ack); end
        wait_ps(400, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL steady_wait_ps: got timeout want period_start"); end
        checks++;
        if (fading !== 1'b0) begin failures++; $display("FAIL steady_fading: got %b want 0", fading); end
        for (int i = 0; i < CH; i++) hi[i] = 0;
        for (int k = 0; k < PER; k++) begin
            cyc();
            for (int i = 0; i < CH; i++) hi[i] += int'(pwm_out[i]);
        end
        for (int i = 0; i < CH; i++) begin
            checks++;
            if (hi[i] != 128) begin failures++; $display("FAIL steady_high_ticks ch%0d: got %0d want 128", i, hi[i]); end
        end
        checks++;
        if (mism !== 0) begin
            failures++; $display("FAIL steady_trace: %0d cycles differ, first t=%0t dut=%h model=%h", mism, bad_t, bad_act, bad_exp);
        end
        mism = 0;
    endtask

    task automatic test_extremes();
        bit ok;
        int hi0, lo1;
        fade_step = SW'($urandom_range(1, 15));
        fade_step = '0;
        pulse_load({8'($urandom), 8'($urandom), 8'hFF, 8'h00});
        wait_ps(400, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL extremes_wait_ps: got timeout want period_start"); end
        hi0 = 0; lo1 = 0;
        for (int k = 0; k < 2*PER + 1; k++) begin
            cyc();
            hi0 += int'(pwm_out[0] === 1'b1);
            lo1 += int'(pwm_out[1] !== 1'b1);
        end
        checks++;
        if (hi0 != 0) begin failures++; $display("FAIL extremes_ch0_low: got %0d high ticks want 0", hi0); end
        checks++;
        if (lo1 != 0) begin failures++; $display("FAIL extremes_ch1_high: got %0d low ticks want 0", lo1); end
        checks++;
        if (mism !== 0) begin
            failures++; $display("FAIL extremes_trace: %0d cycles differ, first t=%0t dut=%h model=%h", mism, bad_t, bad_act, bad_exp);
        end
        mism = 0;
    endtask

    task automatic test_fade_up();
        bit ok;
        int v;
        fade_step = '0;
        pulse_load('0);
        wait_ps(400, ok);
        fade_step = 4'd3;
        pulse_load({CH{8'h10}});
        v = 0;
        for (int b = 0; b < 7; b++) begin
            wait_ps(400, ok);
            v = (v + 3 < 16) ? v + 3 : 16;
            checks++;
            if (!ok || duty_cur !== {CH{8'(v)}}) begin
                failures++; $display("FAIL fade_up_step%0d: got %h want %h", b, duty_cur, {CH{8'(v)}});
            end
            checks++;
            if (fading !== (v != 16)) begin
                failures++; $display("FAIL fade_up_fading%0d: got %b want %b", b, fading, (v != 16));
            end
        end
        checks++;
        if (mism !== 0) begin
            failures++; $display("FAIL fade_up_trace: %0d cycles differ, first t=%0t dut=%h model=%h", mism, bad_t, bad_act, bad_exp);
        end
        mism = 0;
    endtask

    task automatic test_fade_down();
        bit ok;
        int v;
        fade_step = '0;
        pulse_load({CH{8'hFE}});
        wait_ps(400, ok);
        fade_step = 4'd15;
        pulse_load('0);
        v = 254;
        for (int b = 0; b < 18; b++) begin
            wait_ps(400, ok);
            v = (v > 15) ? v - 15 : 0;
            checks++;
            if (!ok || duty_cur !== {CH{8'(v)}}) begin
                failures++; $display("FAIL fade_down_step%0d: got %h want %h", b, duty_cur, {CH{8'(v)}});
            end
        end
        checks++;
        if (fading !== 1'b0) begin failures++; $display("FAIL fade_down_fading: got %b want 0", fading); end
        checks++;
        if (mism !== 0) begin
            failures++; $display("FAIL fade_down_trace: %0d cycles differ, first t=%0t dut=%h model=%h", mism, bad_t, bad_act, bad_exp);
        end
        mism = 0;
    endtask

    task automatic test_load_on_boundary();
        bit ok;
        fade_step = '0;
        pulse_load({CH{8'h20}});
        for (int k = 0; k < 400 && m_pos != PER - 1; k++) cyc();
        duty_in = {CH{8'h40}}; load = 1'b1;
        cyc();
        load = 1'b0;
        checks++;
        if (duty_cur !== {CH{8'h20}}) begin failures++; $display("FAIL lob_old_tgt: got %h want %h", duty_cur, {CH{8'h20}}); end
        checks++;
        if (load_ack !== 1'b1 || period_start !== 1'b1) begin
            failures++; $display("FAIL lob_pulses: got ack=%b ps=%b want 1 1", load_ack, period_start);
        end
        checks++;
        if (fading !== 1'b1) begin failures++; $display("FAIL lob_fading: got %b want 1", fading); end
        cyc();
        checks++;
        if (load_ack !== 1'b0) begin failures++; $display("FAIL lob_ack_width: got %b want 0", load_ack); end
        wait_ps(400, ok);
        checks++;
        if (!ok || duty_cur !== {CH{8'h40}}) begin failures++; $display("FAIL lob_new_tgt: got %h want %h", duty_cur, {CH{8'h40}}); end
        checks++;
        if (mism !== 0) begin
            failures++; $display("FAIL lob_trace: %0d cycles differ, first t=%0t dut=%h model=%h", mism, bad_t, bad_act, bad_exp);
        end
        mism = 0;
    endtask

    task automatic test_sparse_en();
        int ps_at [$];
        int frozen_bad;
        logic [CH-1:0] prev;
        fade_step = SW'($urandom_range(1, 15));
        pulse_load({$urandom});
        frozen_bad = 0;
        for (int k = 0; k < 3*4*PER && ps_at.size() < 3; k++) begin
            en = (k % 4 == 0);
            prev = pwm_out;
            cyc();
            if (!en && pwm_out !== prev) frozen_bad++;
            if (period_start === 1'b1) ps_at.push_back(k);
        end
        checks++;
        if (ps_at.size() < 3) begin
            failures++; $display("FAIL sparse_ps_count: got %0d want 3", ps_at.size());
        end else begin
            checks++;
            if (ps_at[2] - ps_at[1] != 4*PER) begin
                failures++; $display("FAIL sparse_period: got %0d want %0d", ps_at[2] - ps_at[1], 4*PER);
            end
        end
        checks++;
        if (frozen_bad != 0) begin failures++; $display("FAIL sparse_frozen: got %0d changes want 0", frozen_bad); end
        en = 1'b1;
        fade_step = 4'd1;
        pulse_load({CH{8'hF0}});
        for (int k = 0; k < 2*PER + 20; k++) cyc();
        checks++;
        if (fading !== 1'b1) begin failures++; $display("FAIL sparse_midfade: got %b want 1", fading); end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checks++;
        if (dut_vec !== '0) begin failures++; $display("FAIL midfade_reset: got %h want 0", dut_vec); end
        checks++;
        if (mism !== 0) begin
            failures++; $display("FAIL sparse_trace: %0d cycles differ, first t=%0t dut=%h model=%h", mism, bad_t, bad_act, bad_exp);
        end
        mism = 0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 6000; k++) begin
            en        = ($urandom_range(0, 7) != 0);
            load      = ($urandom_range(0, 299) == 0);
            duty_in   = {$urandom};
            fade_step = ($urandom_range(0, 3) == 0) ? SW'($urandom) : fade_step;
            reset     = ($urandom_range(0, 2999) == 0);
            cyc();
        end
        reset = 1'b0; load = 1'b0;
        checks++;
        if (mism !== 0) begin
            failures++; $display("FAIL random_trace: %0d cycles differ, first t=%0t dut=%h model=%h", mism, bad_t, bad_act, bad_exp);
        end
        mism = 0;
    endtask

    initial begin
        mism = 0;
        reset = 1'b1; en = 1'b0; load = 1'b0; duty_in = '0; fade_step = '0;
        test_reset();
        test_steady_half();
        test_extremes();
        test_fade_up();
        test_fade_down();
        test_load_on_boundary();
        test_sparse_en();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
